// File: rtl/cpu_bus_responder_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder_if
// Bundles the CPU byte bus and the UART-side byte streams of the bus responder.
//   CPU side : cpu_addr/cpu_wr/cpu_wdata in, cpu_rdata out (1-cycle read).
//   TX side  : tx_data/tx_valid out, tx_ready in (valid/ready pop).
//   RX side  : rx_data/rx_valid in, rx_ready out (valid/ready push).
//   Status   : prog_halt, tx_overflow, rx_overflow out.
// Modports: slave = the responder, master = CPU plus UART/host environment.
// -----------------------------------------------------------------------------
interface cpu_bus_responder_if;
   logic [31:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        prog_halt;
   logic        tx_overflow;
   logic        rx_overflow;

   modport slave (
      input  cpu_addr, cpu_wr, cpu_wdata, tx_ready, rx_data, rx_valid,
      output cpu_rdata, tx_data, tx_valid, rx_ready, prog_halt,
             tx_overflow, rx_overflow
   );

   modport master (
      output cpu_addr, cpu_wr, cpu_wdata, tx_ready, rx_data, rx_valid,
      input  cpu_rdata, tx_data, tx_valid, rx_ready, prog_halt,
             tx_overflow, rx_overflow
   );
endinterface

// File: rtl/cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder
// Responder end of the CPU byte bus. Serves 2^RAM_ADDR_W bytes of RAM
// (registered read, write at the edge) and an I/O window at addr[17:16]==2'b11:
//   0x30000 R : pop RX FIFO head (0x00 when empty)
//   0x30000 W : push non-zero byte into TX FIFO
//   0x30004 R : snapshot cycle counter into latch, return counter[7:0]
//   0x30005-7 R : latch bytes 1..3
//   0x30004 W : stop request, pushes 0x00 into TX and enters DRAIN
// Ports:
//   clk_in  - clock, all state on the rising edge
//   rst_in  - asynchronous active-low reset
//   bus     - cpu_bus_responder_if.slave (CPU bus, TX/RX streams, status)
// -----------------------------------------------------------------------------
module cpu_bus_responder #(
   parameter int RAM_ADDR_W = 17,
   parameter int TX_DEPTH   = 8,
   parameter int RX_DEPTH   = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   cpu_bus_responder_if.slave   bus
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t state_q, state_d;

   // ---------------------------------------------------------------- decode
   logic io, rd_req, wr_en;
   logic sel_uart, sel_ctr, sel_stop;

   assign io       = (bus.cpu_addr[17:16] == 2'b11);
   assign rd_req   = !bus.cpu_wr;
   // Once a stop has been requested the CPU can no longer change anything.
   assign wr_en    = bus.cpu_wr && (state_q == ST_RUN);
   assign sel_uart = (bus.cpu_addr == 32'h0003_0000);
   // 0x30004..0x30007 share one word; the low two bits pick the byte.
   assign sel_ctr  = (bus.cpu_addr[31:2] == 30'h0000_C001);
   assign sel_stop = sel_ctr && (bus.cpu_addr[1:0] == 2'b00);

   // ------------------------------------------------------------------- RAM
   logic [7:0] ram [2**RAM_ADDR_W];
   logic [7:0] ram_rdata_q;
   logic [RAM_ADDR_W-1:0] ram_addr;
   logic ram_we, ram_re;

   assign ram_addr = bus.cpu_addr[RAM_ADDR_W-1:0];
   assign ram_we   = wr_en && !io;
   assign ram_re   = rd_req && !io;

   // No reset here so the array and its output register map onto block RAM.
   always_ff @(posedge clk_in) begin
      if (ram_we)
         ram[ram_addr] <= bus.cpu_wdata;
      if (ram_re)
         ram_rdata_q <= ram[ram_addr];
   end

   // --------------------------------------------------------------- TX FIFO
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wptr_q, tx_rptr_q;
   logic [TX_AW:0]   tx_count_q;
   logic             tx_full, tx_empty, tx_pop, tx_req, tx_push, tx_drop;
   logic [7:0]       tx_wbyte;

   assign tx_full  = (tx_count_q == TX_FULL_CNT);
   assign tx_empty = (tx_count_q == '0);
   assign tx_pop   = !tx_empty && bus.tx_ready;
   // Zero bytes written to the data port are discarded; the stop port
   // always queues a 0x00 marker for the host.
   assign tx_req   = wr_en && ((sel_uart && (bus.cpu_wdata != 8'h00)) || sel_stop);
   assign tx_wbyte = sel_stop ? 8'h00 : bus.cpu_wdata;
   // A pop in the same cycle makes room, so a full FIFO still accepts.
   assign tx_push  = tx_req && (!tx_full || tx_pop);
   assign tx_drop  = tx_req && tx_full && !tx_pop;

   always_ff @(posedge clk_in) begin
      if (tx_push)
         tx_mem[tx_wptr_q] <= tx_wbyte;
   end

   assign bus.tx_data  = tx_mem[tx_rptr_q];
   assign bus.tx_valid = !tx_empty;

   // --------------------------------------------------------------- RX FIFO
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wptr_q, rx_rptr_q;
   logic [RX_AW:0]   rx_count_q;
   logic             rx_full, rx_empty, rx_pop, rx_push, rx_drop;

   assign rx_full  = (rx_count_q == RX_FULL_CNT);
   assign rx_empty = (rx_count_q == '0);
   assign rx_pop   = rd_req && sel_uart && !rx_empty;
   assign rx_push  = bus.rx_valid && (!rx_full || rx_pop);
   assign rx_drop  = bus.rx_valid && rx_full && !rx_pop;

   always_ff @(posedge clk_in) begin
      if (rx_push)
         rx_mem[rx_wptr_q] <= bus.rx_data;
   end

   assign bus.rx_ready = !rx_full;

   // ------------------------------------------------- counter and IO reads
   logic [31:0] counter_q, latch_q;
   logic [7:0]  io_rdata_d, io_rdata_q;
   logic        sel_ram_q;

   always_comb begin
      io_rdata_d = 8'h00;
      if (sel_uart) begin
         if (!rx_empty)
            io_rdata_d = rx_mem[rx_rptr_q];
      end else if (sel_ctr) begin
         // Byte 0 is live; bytes 1..3 come from the last snapshot.
         if (bus.cpu_addr[1:0] == 2'b00)
            io_rdata_d = counter_q[7:0];
         else
            io_rdata_d = latch_q[{bus.cpu_addr[1:0], 3'b000} +: 8];
      end
   end

   // The RAM path and the IO path each keep their own holding register;
   // sel_ram_q remembers which one the most recent read targeted.
   assign bus.cpu_rdata = sel_ram_q ? ram_rdata_q : io_rdata_q;

   // ------------------------------------------------------------------ FSM
   logic prog_halt;

   always_comb begin
      state_d   = state_q;
      prog_halt = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (wr_en && sel_stop)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (tx_empty)
               state_d = ST_HALTED;
         end
         ST_HALTED: begin
            prog_halt = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign bus.prog_halt = prog_halt;

   // ------------------------------------------------------ state registers
   logic tx_overflow_q, rx_overflow_q;

   assign bus.tx_overflow = tx_overflow_q;
   assign bus.rx_overflow = rx_overflow_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= ST_RUN;
         counter_q     <= '0;
         latch_q       <= '0;
         io_rdata_q    <= '0;
         sel_ram_q     <= 1'b0;
         tx_wptr_q     <= '0;
         tx_rptr_q     <= '0;
         tx_count_q    <= '0;
         rx_wptr_q     <= '0;
         rx_rptr_q     <= '0;
         rx_count_q    <= '0;
         tx_overflow_q <= 1'b0;
         rx_overflow_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_q + 32'd1;

         if (rd_req) begin
            sel_ram_q <= !io;
            if (io)
               io_rdata_q <= io_rdata_d;
         end
         if (rd_req && sel_stop)
            latch_q <= counter_q;

         if (tx_push)
            tx_wptr_q <= tx_wptr_q + 1'b1;
         if (tx_pop)
            tx_rptr_q <= tx_rptr_q + 1'b1;
         if (tx_push && !tx_pop)
            tx_count_q <= tx_count_q + 1'b1;
         else if (tx_pop && !tx_push)
            tx_count_q <= tx_count_q - 1'b1;

         if (rx_push)
            rx_wptr_q <= rx_wptr_q + 1'b1;
         if (rx_pop)
            rx_rptr_q <= rx_rptr_q + 1'b1;
         if (rx_push && !rx_pop)
            rx_count_q <= rx_count_q + 1'b1;
         else if (rx_pop && !rx_push)
            rx_count_q <= rx_count_q - 1'b1;

         if (tx_drop)
            tx_overflow_q <= 1'b1;
         if (rx_drop)
            rx_overflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_responder
// Directed scenarios followed by randomized traffic. A queue/array model of
// the responder is stepped on every rising edge and compared against the DUT
// one time unit later; directed scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cpu_bus_responder;

   localparam logic [31:0] A_UART = 32'h0003_0000;
   localparam logic [31:0] A_CTR  = 32'h0003_0004;
   localparam logic [31:0] A_IDLE = 32'h0003_0010;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic tx_rdy = 1'b0;

   int checks = 0;
   int errors = 0;

   cpu_bus_responder_if bus();

   cpu_bus_responder #(
      .RAM_ADDR_W (17),
      .TX_DEPTH   (8),
      .RX_DEPTH   (4)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------- behavioural model
   logic [7:0]  m_ram [int];
   logic [7:0]  m_tx [$];
   logic [7:0]  m_rx [$];
   logic [31:0] m_cnt   = 0;
   logic [31:0] m_latch = 0;
   logic [7:0]  m_rdata = 0;
   bit          m_rdata_known = 1;
   bit          m_txov = 0;
   bit          m_rxov = 0;
   int          m_phase = 0;   // 0 running, 1 stop requested, 2 halted

   initial begin
      forever begin
         @(posedge clk_in);
         if (!rst_in) begin
            m_tx.delete();
            m_rx.delete();
            m_cnt = 0; m_latch = 0; m_rdata = 0; m_rdata_known = 1;
            m_txov = 0; m_rxov = 0; m_phase = 0;
         end else begin
            logic [31:0] a;
            logic        wr, rxv;
            logic [7:0]  wd, rxd, tb_byte;
            int          tx_n, rx_n, ph;
            bit          io, tx_pop, rx_pop, tx_req;
            a = bus.cpu_addr; wr = bus.cpu_wr; wd = bus.cpu_wdata;
            rxv = bus.rx_valid; rxd = bus.rx_data;
            tx_n = m_tx.size(); rx_n = m_rx.size(); ph = m_phase;
            io = (a[17:16] == 2'b11);
            tx_pop = (tx_n > 0) && bus.tx_ready;
            rx_pop = 0; tx_req = 0; tb_byte = 8'h00;
            if (!wr) begin
               if (!io) begin
                  m_rdata_known = m_ram.exists(int'(a[16:0]));
                  if (m_rdata_known) m_rdata = m_ram[int'(a[16:0])];
               end else begin
                  m_rdata_known = 1;
                  m_rdata = 8'h00;
                  if (a == A_UART && rx_n > 0) begin
                     m_rdata = m_rx[0];
                     rx_pop = 1;
                  end else if (a == A_CTR) begin
                     m_rdata = m_cnt[7:0];
                     m_latch = m_cnt;
                  end else if (a >= 32'h0003_0005 && a <= 32'h0003_0007) begin
                     m_rdata = 8'(m_latch >> (8 * (a - A_CTR)));
                  end
               end
            end else if (ph == 0) begin
               if (!io) m_ram[int'(a[16:0])] = wd;
               else if (a == A_UART && wd != 8'h00) begin tx_req = 1; tb_byte = wd; end
               else if (a == A_CTR) begin tx_req = 1; tb_byte = 8'h00; m_phase = 1; end
            end
            if (ph == 1 && tx_n == 0) m_phase = 2;
            if (tx_pop) void'(m_tx.pop_front());
            if (tx_req) begin
               if (tx_n == 8 && !tx_pop) m_txov = 1;
               else m_tx.push_back(tb_byte);
            end
            if (rx_pop) void'(m_rx.pop_front());
            if (rxv) begin
               if (rx_n == 4 && !rx_pop) m_rxov = 1;
               else m_rx.push_back(rxd);
            end
            m_cnt = m_cnt + 1;
         end
         #1;
         if (m_rdata_known) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rdata));
         chk("tx_valid", 32'(bus.tx_valid), 32'(m_tx.size() != 0));
         if (m_tx.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(m_tx[0]));
         chk("rx_ready", 32'(bus.rx_ready), 32'(m_rx.size() < 4));
         chk("prog_halt", 32'(bus.prog_halt), 32'(m_phase == 2));
         chk("tx_overflow", 32'(bus.tx_overflow), 32'(m_txov));
         chk("rx_overflow", 32'(bus.rx_overflow), 32'(m_rxov));
      end
   end

   // --------------------------------------------------------------- driving
   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] wd,
                       input logic rxv = 1'b0, input logic [7:0] rxd = 8'h00);
      @(negedge clk_in);
      bus.cpu_addr  = a;
      bus.cpu_wr    = wr;
      bus.cpu_wdata = wd;
      bus.rx_valid  = rxv;
      bus.rx_data   = rxd;
      bus.tx_ready  = tx_rdy;
      if (a != A_IDLE || wr || rxv)
         $display("txn t=%0t %s addr=0x%05h wdata=0x%02h rx_valid=%0b rx_data=0x%02h tx_ready=%0b",
                  $time, wr ? "WR" : "RD", a, wd, rxv, rxd, tx_rdy);
   endtask

   task automatic after_edge();
      @(posedge clk_in);
      #2;
   endtask

   task automatic reset_pulse();
      @(negedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'h1);
      chk("rst_prog_halt", 32'(bus.prog_halt), 32'h0);
      chk("rst_overflows", {30'd0, bus.tx_overflow, bus.rx_overflow}, 32'h0);
      @(negedge clk_in);
      bus.cpu_addr = A_IDLE; bus.cpu_wr = 1'b0; bus.cpu_wdata = 8'h00;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = tx_rdy;
      rst_in = 1'b1;
   endtask

   initial begin
      bus.cpu_addr = A_IDLE; bus.cpu_wr = 1'b0; bus.cpu_wdata = 8'h00;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;

      // Out of reset
      after_edge();
      chk("init_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
      chk("init_rx_ready", 32'(bus.rx_ready), 32'h1);
      @(negedge clk_in);
      rst_in = 1'b1;

      // RAM write then read-back on the following cycle
      step(32'h0000_0123, 1'b1, 8'h5A);
      step(32'h0000_0123, 1'b0, 8'h00);
      after_edge();
      chk("ram_readback", 32'(bus.cpu_rdata), 32'h5A);

      // TX pushes, zero byte ignored, then drain
      tx_rdy = 1'b0;
      step(A_UART, 1'b1, 8'h41);
      step(A_UART, 1'b1, 8'h00);
      step(A_UART, 1'b1, 8'h42);
      after_edge();
      chk("tx_head_41", 32'(bus.tx_data), 32'h41);
      tx_rdy = 1'b1;
      step(A_IDLE, 1'b0, 8'h00);
      after_edge();
      chk("tx_head_42", 32'(bus.tx_data), 32'h42);
      step(A_IDLE, 1'b0, 8'h00);
      after_edge();
      chk("tx_empty_after_2", 32'(bus.tx_valid), 32'h0);

      // TX overflow: ninth byte with no pop is dropped
      tx_rdy = 1'b0;
      reset_pulse();
      for (int i = 1; i <= 9; i++) step(A_UART, 1'b1, 8'(i));
      step(A_IDLE, 1'b0, 8'h00);
      after_edge();
      chk("tx_overflow_set", 32'(bus.tx_overflow), 32'h1);
      tx_rdy = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("tx_order_ovf", 32'(bus.tx_data), 32'(i));
         step(A_IDLE, 1'b0, 8'h00);
         after_edge();
      end
      chk("tx_drained_8", 32'(bus.tx_valid), 32'h0);

      // Ninth byte together with a pop is accepted
      tx_rdy = 1'b0;
      reset_pulse();
      for (int i = 1; i <= 8; i++) step(A_UART, 1'b1, 8'(i));
      tx_rdy = 1'b1;
      step(A_UART, 1'b1, 8'h09);
      after_edge();
      chk("tx_no_overflow", 32'(bus.tx_overflow), 32'h0);
      for (int i = 2; i <= 9; i++) begin
         chk("tx_order_full_pop", 32'(bus.tx_data), 32'(i));
         step(A_IDLE, 1'b0, 8'h00);
         after_edge();
      end
      chk("tx_drained_9", 32'(bus.tx_valid), 32'h0);

      // RX FIFO reads and overflow
      tx_rdy = 1'b0;
      reset_pulse();
      step(A_IDLE, 1'b0, 8'h00, 1'b1, 8'h11);
      step(A_IDLE, 1'b0, 8'h00, 1'b1, 8'h22);
      step(A_UART, 1'b0, 8'h00);
      after_edge();
      chk("rx_read_11", 32'(bus.cpu_rdata), 32'h11);
      step(A_UART, 1'b0, 8'h00);
      after_edge();
      chk("rx_read_22", 32'(bus.cpu_rdata), 32'h22);
      step(A_UART, 1'b0, 8'h00);
      after_edge();
      chk("rx_read_empty", 32'(bus.cpu_rdata), 32'h00);
      for (int i = 0; i < 5; i++) begin
         step(A_IDLE, 1'b0, 8'h00, 1'b1, 8'(8'hA0 + i));
         after_edge();
         if (i == 3) begin
            chk("rx_ready_full", 32'(bus.rx_ready), 32'h0);
            chk("rx_ovf_not_yet", 32'(bus.rx_overflow), 32'h0);
         end
      end
      chk("rx_overflow_set", 32'(bus.rx_overflow), 32'h1);
      step(A_IDLE, 1'b0, 8'h00);

      // Counter snapshot at 0x1F3, latched high byte read later
      reset_pulse();
      repeat (498) @(negedge clk_in);
      step(A_CTR, 1'b0, 8'h00);
      after_edge();
      chk("ctr_byte0", 32'(bus.cpu_rdata), 32'hF3);
      for (int i = 0; i < 10; i++) step(A_IDLE, 1'b0, 8'h00);
      step(32'h0003_0005, 1'b0, 8'h00);
      after_edge();
      chk("ctr_latch_b1", 32'(bus.cpu_rdata), 32'h01);
      step(32'h0003_0006, 1'b0, 8'h00);
      after_edge();
      chk("ctr_latch_b2", 32'(bus.cpu_rdata), 32'h00);

      // Stop: DRAIN ignores writes, HALTED one cycle after TX empties
      tx_rdy = 1'b0;
      reset_pulse();
      step(32'h0000_0010, 1'b1, 8'h33);
      step(A_UART, 1'b1, 8'h41);
      step(A_CTR, 1'b1, 8'h00);
      step(32'h0000_0010, 1'b1, 8'h77);
      step(32'h0000_0010, 1'b0, 8'h00);
      after_edge();
      chk("drain_ram_kept", 32'(bus.cpu_rdata), 32'h33);
      chk("drain_head_41", 32'(bus.tx_data), 32'h41);
      tx_rdy = 1'b1;
      step(A_IDLE, 1'b0, 8'h00);
      after_edge();
      chk("drain_head_00", {31'd0, bus.tx_valid} | {24'd0, bus.tx_data} << 1, 32'h1);
      step(A_IDLE, 1'b0, 8'h00);
      after_edge();
      chk("drain_empty", 32'(bus.tx_valid), 32'h0);
      chk("halt_not_yet", 32'(bus.prog_halt), 32'h0);
      step(A_IDLE, 1'b0, 8'h00);
      after_edge();
      chk("halt_set", 32'(bus.prog_halt), 32'h1);
      step(A_UART, 1'b1, 8'h55);
      after_edge();
      chk("halted_write_ignored", 32'(bus.tx_valid), 32'h0);
      reset_pulse();

      // Reset in the middle of DRAIN
      tx_rdy = 1'b0;
      step(A_UART, 1'b1, 8'h41);
      step(A_CTR, 1'b1, 8'h00);
      step(A_IDLE, 1'b0, 8'h00);
      after_edge();
      chk("mid_drain_valid", 32'(bus.tx_valid), 32'h1);
      reset_pulse();

      // Randomized traffic
      for (int seg = 0; seg < 4; seg++) begin
         reset_pulse();
         for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic        wr, rxv;
            logic [7:0]  wd;
            int          r;
            r  = $urandom_range(0, 15);
            wr = 1'($urandom_range(0, 1));
            wd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if (r <= 5)       a = 32'($urandom_range(0, 31));
            else if (r <= 8)  a = A_UART;
            else if (r == 9) begin
               a = A_CTR;
               if ($urandom_range(0, 29) != 0) wr = 1'b0;
            end
            else if (r <= 12) a = 32'h0003_0004 + 32'($urandom_range(1, 3));
            else if (r == 13) a = A_IDLE;
            else              a = 32'h0001_FFF0 + 32'($urandom_range(0, 15));
            rxv    = ($urandom_range(0, 9) < 4);
            tx_rdy = 1'($urandom_range(0, 1));
            step(a, wr, wd, rxv, 8'($urandom));
         end
         step(A_IDLE, 1'b0, 8'h00);
         after_edge();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
